// File: rtl/memory_stage.sv
// Y86 SEQ memory stage: byte-serial 64-bit load/store into an internal byte-wide data
// memory, with a start/done handshake and an address range check.
module memory_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int BYTES_PW  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - BYTES_PW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [63:0]   valm_q, valm_d;
  logic          err_q, err_d;

  logic [7:0]    mem_q [MEM_BYTES];

  logic          req_wr, req_rd;
  logic [63:0]   req_addr, req_wdata;
  logic [AW-1:0] byte_idx;
  logic [7:0]    mem_rdata, mem_wdata;
  logic          mem_we;

  // Instruction decode: which access, which address, which write data.
  always_comb begin
    req_wr    = 1'b0;
    req_rd    = 1'b0;
    req_addr  = valE;
    req_wdata = valA;
    case (icode)
      4'h4, 4'hA: req_wr = 1'b1;
      4'h8: begin
        req_wr    = 1'b1;
        req_wdata = valP;
      end
      4'h5: req_rd = 1'b1;
      4'h9, 4'hB: begin
        req_rd   = 1'b1;
        req_addr = valA;
      end
      default: ;
    endcase
  end

  assign byte_idx  = addr_q + AW'(cnt_q);
  assign mem_rdata = mem_q[byte_idx];
  assign mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
  // Reset wins over the byte write in flight, so an interrupted store stops cleanly.
  assign mem_we    = (state_q == S_XFER) && wr_q && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    valm_d  = valm_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          wr_d    = req_wr;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          cnt_d   = 3'd0;
          if (!req_wr && !req_rd) begin
            state_d = S_DONE;
          end else if (req_addr > MAX_ADDR) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_XFER;
            if (req_rd) valm_d = 64'd0;
          end
        end
      end
      S_XFER: begin
        if (!wr_q) valm_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      valm_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  // Latched request fields only matter outside IDLE, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[byte_idx] <= mem_wdata;
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign valM       = valm_q;
  assign dmem_error = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized checks of memory_stage against a byte-array reference model.
module tb_memory_stage;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        busy, done, dmem_error;
  logic [63:0] valM;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  ref_mem [MEM_BYTES];
  logic [63:0] model_valm;

  memory_stage #(.MEM_BYTES(MEM_BYTES), .BYTES_PW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one accepted request: expected latency and error flag,
  // with the model memory and model valM updated as the instruction would.
  task automatic model(input logic [3:0] ic, input logic [63:0] e, a, p,
                       output int lat, output logic err);
    logic        wr, rd;
    logic [63:0] addr, wd;
    int          base;
    wr   = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
    wd   = (ic == 4'h8) ? p : a;
    lat  = 1;
    err  = 1'b0;
    if (wr || rd) begin
      if (addr > 64'(MEM_BYTES - 8)) begin
        err = 1'b1;
      end else begin
        lat  = 9;
        base = int'(addr[31:0]);
        for (int i = 0; i < 8; i++) begin
          if (wr) ref_mem[base + i] = wd[8*i +: 8];
          else    model_valm[8*i +: 8] = ref_mem[base + i];
        end
      end
    end
  endtask

  task automatic txn(input logic [3:0] ic, input logic [63:0] e, a, p);
    int   exp_lat, cyc, busy_cnt;
    logic exp_err;
    model(ic, e, a, p, exp_lat, exp_err);
    icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
    tick();
    start = 1'b0;
    icode = 4'($urandom);
    valE  = {$urandom, $urandom};
    valA  = {$urandom, $urandom};
    valP  = {$urandom, $urandom};
    cyc = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    if (busy === 1'b1) busy_cnt++;
    check("latency", 64'(cyc), 64'(exp_lat));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
    check("valM", valM, model_valm);
    check("dmem_error", 64'(dmem_error), 64'(exp_err));
    tick();
    check("done_one_pulse", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("valM_held", valM, model_valm);
    check("err_held", 64'(dmem_error), 64'(exp_err));
  endtask

  initial begin
    logic [3:0] ic_tab [9];
    int         lat;
    logic       err;
    int         dones, busy_cnt, cyc;
    ic_tab = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h6, 4'h1};

    reset = 1'b1; start = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    tick(); tick();
    reset = 1'b0;
    model_valm = 64'd0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_valM", valM, 64'd0);
    check("reset_err", 64'(dmem_error), 64'd0);

    // Give every byte a known value so later reads are fully predictable.
    for (int ad = 0; ad < MEM_BYTES; ad += 8)
      txn(4'h4, 64'(ad), {$urandom, $urandom}, 64'd0);

    // Store then load a quadword.
    txn(4'h4, 64'h100, 64'h0123456789ABCDEF, 64'd0);
    txn(4'h5, 64'h100, 64'd0, 64'd0);
    check("t1_load_value", valM, 64'h0123456789ABCDEF);

    // Push, pop, and call.
    txn(4'hA, 64'h3F8, 64'hDEADBEEF, 64'd0);
    txn(4'hB, 64'd0, 64'h3F8, 64'd0);
    check("t2_pop_value", valM, 64'hDEADBEEF);
    txn(4'h8, 64'h200, 64'd0, 64'h42);
    txn(4'h5, 64'h200, 64'd0, 64'd0);
    check("t2_call_value", valM, 64'h42);

    // Out-of-range accesses, then confirm memory is untouched.
    txn(4'h5, 64'(MEM_BYTES - 4), 64'd0, 64'd0);
    check("t3_read_err", 64'(dmem_error), 64'd1);
    txn(4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0);
    check("t3_write_err", 64'(dmem_error), 64'd1);
    txn(4'h5, 64'h3F8, 64'd0, 64'd0);
    txn(4'h5, 64'd0, 64'd0, 64'd0);
    txn(4'h4, 64'(MEM_BYTES - 8), 64'h5555_6666_7777_8888, 64'd0);
    check("t3_last_ok", 64'(dmem_error), 64'd0);

    // Start held high: one transfer, then a second only after IDLE is reached.
    model(4'h4, 64'h40, 64'hCAFE_F00D_1234_5678, 64'd0, lat, err);
    icode = 4'h4; valE = 64'h40; valA = 64'hCAFE_F00D_1234_5678; valP = 64'd0;
    start = 1'b1;
    dones = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busy_cnt++;
      if (k == 9) check("t4_done_at_9", 64'(done), 64'd1);
    end
    check("t4_done_pulses", 64'(dones), 64'd1);
    check("t4_busy_cycles", 64'(busy_cnt), 64'd9);
    check("t4_idle_at_10", 64'(busy), 64'd0);
    tick();
    check("t4_second_start", 64'(busy), 64'd1);
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    check("t4_second_done", 64'(done), 64'd1);
    tick();
    txn(4'h5, 64'h40, 64'd0, 64'd0);

    // Reset in the middle of a store: first three bytes land, the rest do not.
    icode = 4'h4; valE = 64'h80; valA = 64'h1111_1111_1111_1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) ref_mem[16'h80 + i] = 8'h11;
    model_valm = 64'd0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_valM", valM, 64'd0);
    check("t5_err", 64'(dmem_error), 64'd0);
    txn(4'h5, 64'h80, 64'd0, 64'd0);

    // Non-memory instruction after an error: error clears, valM untouched.
    txn(4'h5, 64'(MEM_BYTES), 64'd0, 64'd0);
    txn(4'h6, 64'h10, 64'h20, 64'h30);
    check("t6_no_err", 64'(dmem_error), 64'd0);

    // Random mix of instructions and addresses.
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  ic;
      logic [63:0] ad;
      ic = ic_tab[$urandom_range(0, 8)];
      case ($urandom_range(0, 7))
        0:       ad = 64'($urandom_range(MEM_BYTES - 7, MEM_BYTES + 64));
        1:       ad = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        default: ad = 64'($urandom_range(0, MEM_BYTES - 8));
      endcase
      if (ic == 4'h9 || ic == 4'hB) txn(ic, {$urandom, $urandom}, ad, {$urandom, $urandom});
      else                          txn(ic, ad, {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
